// File: rtl/i2c_req_arbiter.sv
// rtl/i2c_req_arbiter.sv - round-robin arbiter/sequencer sharing one i2c_master_2 among NUM_REQ requesters
module i2c_req_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int START_TIMEOUT = 1000,
    parameter int BUSY_TIMEOUT  = 200000
) (
    input  logic                          clk_i,
    input  logic                          rstn_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            req_write_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_target_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic [NUM_REQ-1:0]            rsp_valid_o,
    output logic [DATA_WIDTH-1:0]         rsp_rdata_o,
    output logic                          rsp_err_o,
    output logic                          m_start_o,
    output logic                          m_write_o,
    output logic [DATA_WIDTH-1:0]         m_target_o,
    output logic [DATA_WIDTH-1:0]         m_addr_o,
    output logic [DATA_WIDTH-1:0]         m_data_o,
    input  logic [DATA_WIDTH-1:0]         m_rdata_i,
    input  logic                          m_busy_i,
    input  logic                          m_err_i
);
    localparam int IW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int T_MAX = (START_TIMEOUT > BUSY_TIMEOUT) ? START_TIMEOUT : BUSY_TIMEOUT;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_BUSY,
        S_DRAIN,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [IW-1:0]           last_gnt_q, last_gnt_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [NUM_REQ-1:0]      gnt_d, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_d;
    logic                    rsp_err_d;
    logic                    m_start_d, m_write_d;
    logic [DATA_WIDTH-1:0]   m_target_d, m_addr_d, m_data_d;

    logic [IW-1:0]           pick;
    logic [IW-1:0]           idx_w;
    logic                    found;
    int                      arb_idx;

    // Search starts one past the last winner so simultaneous requests rotate.
    always_comb begin
        pick    = last_gnt_q;
        found   = 1'b0;
        arb_idx = 0;
        idx_w   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            arb_idx = (int'(last_gnt_q) + i) % NUM_REQ;
            idx_w   = IW'(arb_idx);
            if (!found && req_i[idx_w]) begin
                found = 1'b1;
                pick  = idx_w;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        timer_d     = timer_q;
        gnt_d       = gnt_o;
        rsp_valid_d = '0;
        rsp_rdata_d = rsp_rdata_o;
        rsp_err_d   = rsp_err_o;
        m_start_d   = m_start_o;
        m_write_d   = m_write_o;
        m_target_d  = m_target_o;
        m_addr_d    = m_addr_o;
        m_data_d    = m_data_o;

        unique case (state_q)
            S_IDLE: begin
                timer_d = '0;
                if (found) begin
                    gnt_d      = ONE_HOT0 << pick;
                    last_gnt_d = pick;
                    m_write_d  = req_write_i[pick];
                    m_target_d = req_target_i[pick*DATA_WIDTH +: DATA_WIDTH];
                    m_addr_d   = req_addr_i[pick*DATA_WIDTH +: DATA_WIDTH];
                    m_data_d   = req_data_i[pick*DATA_WIDTH +: DATA_WIDTH];
                    m_start_d  = 1'b1;
                    state_d    = S_ISSUE;
                end
            end

            S_ISSUE: begin
                if (m_busy_i) begin
                    m_start_d = 1'b0;
                    timer_d   = '0;
                    state_d   = S_BUSY;
                end else if (timer_q == TW'(START_TIMEOUT - 1)) begin
                    m_start_d   = 1'b0;
                    rsp_valid_d = gnt_o;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            S_BUSY: begin
                if (!m_busy_i) begin
                    rsp_valid_d = gnt_o;
                    rsp_err_d   = m_err_i;
                    rsp_rdata_d = (m_write_o || m_err_i) ? '0 : m_rdata_i;
                    state_d     = S_RESP;
                end else if (timer_q == TW'(BUSY_TIMEOUT - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            // A hung master must finish before the bus is handed on; the error is already decided.
            S_DRAIN: begin
                if (!m_busy_i) begin
                    rsp_valid_d = gnt_o;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    state_d     = S_RESP;
                end
            end

            S_RESP: begin
                gnt_d   = '0;
                timer_d = '0;
                state_d = S_IDLE;
            end

            default: begin
                gnt_d     = '0;
                m_start_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= S_IDLE;
            last_gnt_q  <= IW'(NUM_REQ - 1);
            timer_q     <= '0;
            gnt_o       <= '0;
            rsp_valid_o <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            m_start_o   <= 1'b0;
            m_write_o   <= 1'b0;
            m_target_o  <= '0;
            m_addr_o    <= '0;
            m_data_o    <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            timer_q     <= timer_d;
            gnt_o       <= gnt_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_rdata_o <= rsp_rdata_d;
            rsp_err_o   <= rsp_err_d;
            m_start_o   <= m_start_d;
            m_write_o   <= m_write_d;
            m_target_o  <= m_target_d;
            m_addr_o    <= m_addr_d;
            m_data_o    <= m_data_d;
        end
    end

endmodule
